regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 32x32 register file between two writeback sources and tracks which registers have a write still in flight. Requester A (ALU writeback) has fixed priority; requester B (load/multi-cycle unit) is protected by a starvation counter. A 32-bit busy scoreboard is set when an instruction reserves its destination and cleared when the register file commits the write. The decode stage queries this scoreboard for RAW/WAW stalls.

## Interface
- STARVE_LIMIT, 3, consecutive cycles B may lose arbitration before it is forced to win; legal range ≥1
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- a_valid  in  1  requester A has a write
- a_rd  in  5  A destination register
- a_data  in  32  A write data
- a_ready  out  1  A write accepted this cycle when a_valid=1
- b_valid, b_rd, b_data, b_ready  same widths and roles as A, requester B
- reserve_valid  in  1  decode reserves a destination this cycle
- reserve_rd  in  5  register to mark busy
- rs1, rs2  in  5  scoreboard query addresses
- rs1_busy, rs2_busy  out  1  combinational busy bit of rs1/rs2; always 0 for address 0
- rf_we  out  1  register file write enable, registered
- rf_w  out  5  register file write address, registered
- rf_data  out  32  register file write data, registered
- reserve_conflict  out  1  registered one-cycle pulse: reserve hit an already-busy register

## Operation
- Starved = starve_cnt ≥ STARVE_LIMIT. starve_cnt width is $clog2(STARVE_LIMIT+1) and saturates at STARVE_LIMIT.
- Grants are combinational from the current state:
  - a_ready = !(b_valid && starved)
  - b_ready = !a_valid || starved
  - At most one handshake (valid && ready) occurs per cycle.
- Counter update each edge:
  - +1 when b_valid && !b_ready
  - 0 when a B handshake occurs, or when b_valid=0
- On a handshake, the next edge loads rf_w/rf_data from the winner and sets rf_we=1.
  - A winning rd of 0 completes the handshake but leaves rf_we=0.
  - rf_we is 0 in every cycle without a handshake. rf_w/rf_data hold their last value.
- Scoreboard busy[31:0]; busy[0] is hardwired to 0.
  - Set: reserve_valid with reserve_rd≠0 sets busy[reserve_rd] at the next edge.
  - Clear: busy[rf_w] clears at the edge where rf_we=1 is sampled. This is the same edge on which the register file commits.
  - Same register set and cleared on the same edge: set wins (new writer in flight).
  - Reserve of a register already busy (and not being cleared that edge): busy stays 1, and reserve_conflict=1 for the next cycle.
  - reserve_rd=0 is ignored entirely: no set, no conflict.
- rs1_busy/rs2_busy read the current busy register. There is no bypass of same-cycle reserve or clear.

## Timing
- Reset (rst_n=0 sampled at an edge) clears:
  - rf_we=0, rf_w=0, rf_data=0
  - busy=0, starve_cnt=0, reserve_conflict=0
  - A handshake in the reset cycle is discarded; no rf_we pulse follows reset.
- While rst_n=0, a_ready/b_ready still follow the formulas above, driven by the reset state.
- Latency:
  - Handshake in cycle N → rf_we=1 in cycle N+1 → data in the register file after edge N+2.
  - busy clears at edge N+2, so rsX_busy reads 0 from cycle N+2.
  - Reserve in cycle N → busy visible in cycle N+1.
- Worst-case wait for B under continuous A traffic: STARVE_LIMIT cycles of loss, then a guaranteed win in the next cycle.
- Back-to-back handshakes every cycle are supported. rf_we stays high continuously.

## Test plan
- **Reset:** drive rst_n=0 with a_valid=1 → rf_we=0 in the cycle after reset and no busy bits set. Deassert reset, a_valid=1, a_rd=5, a_data=0x1234 → rf_we=1, rf_w=5, rf_data=0x1234 one cycle later.
- **Priority and starvation (STARVE_LIMIT=3):** a_valid and b_valid held high → A wins 3 consecutive cycles, B wins the 4th, then A wins 3 more. Check that only one ready/valid pair completes per cycle.
- **Scoreboard lifecycle:** reserve r7 → rs1=7 gives rs1_busy=1 next cycle. B writes r7 with 0xDEADBEEF → rs1_busy=0 two cycles after the handshake, and the register file reads 0xDEADBEEF.
- **Simultaneous set/clear on r9:** reserve r9 on the edge where the rf_we write to r9 commits → busy[9] remains 1 and reserve_conflict=0. A second reserve of r9 while busy → reserve_conflict pulses for 1 cycle.
- **x0 handling:** reserve_rd=0 → no busy bit and no conflict. A writes rd=0 → a_ready=1, rf_we stays 0, rs1=0 gives rs1_busy=0.
- **Reset mid-operation:** handshake in cycle N, rst_n=0 sampled at edge N+1 → no rf_we pulse, busy=0, starve_cnt=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter
//  Purpose  : Shares the register-file write port between ALU writeback (A,
//             fixed priority) and the load/multi-cycle unit (B, protected by a
//             starvation counter). Keeps a busy scoreboard of destinations
//             with writes in flight for decode RAW/WAW stall checks.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        reserve_valid,
  input  logic [4:0]  reserve_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rf_we,
  output logic [4:0]  rf_w,
  output logic [31:0] rf_data,
  output logic        reserve_conflict
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          a_hs;
  logic          b_hs;
  logic          win_valid;
  logic [4:0]    win_rd;
  logic [31:0]   win_data;
  logic [31:0]   busy;
  logic [31:0]   busy_set;
  logic [31:0]   busy_clr;
  logic [31:0]   busy_next;
  logic          conflict_next;

  // B is forced to win once it has lost STARVE_LIMIT consecutive cycles.
  assign starved = (starve_cnt >= LIMIT);
  assign a_ready = !(b_valid && starved);
  assign b_ready = !a_valid || starved;
  assign a_hs    = a_valid && a_ready;
  assign b_hs    = b_valid && b_ready;

  // The two handshakes are mutually exclusive, so a simple mux picks the winner.
  always_comb begin
    win_valid = a_hs || b_hs;
    win_rd    = a_hs ? a_rd   : b_rd;
    win_data  = a_hs ? a_data : b_data;
  end

  // Starvation counter: counts consecutive B losses, saturating at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!b_valid || b_hs) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered write port; a winner targeting x0 is consumed without a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_w    <= '0;
      rf_data <= '0;
    end else begin
      rf_we <= win_valid && (win_rd != 5'd0);
      if (win_valid && (win_rd != 5'd0)) begin
        rf_w    <= win_rd;
        rf_data <= win_data;
      end
    end
  end

  // Scoreboard next state: clear on commit, set on reserve, set wins ties.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (reserve_valid) begin
      busy_set[reserve_rd] = 1'b1;
    end
    if (rf_we) begin
      busy_clr[rf_w] = 1'b1;
    end
    busy_next    = (busy & ~busy_clr) | busy_set;
    busy_next[0] = 1'b0;
    conflict_next = reserve_valid && (reserve_rd != 5'd0) &&
                    busy[reserve_rd] && !busy_clr[reserve_rd];
  end

  // Scoreboard and conflict pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy             <= '0;
      reserve_conflict <= 1'b0;
    end else begin
      busy             <= busy_next;
      reserve_conflict <= conflict_next;
    end
  end

  // Queries see the registered scoreboard only; busy[0] is always zero.
  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_write_arbiter
//  Purpose  : Randomized scoreboard bench for regfile_write_arbiter against a
//             behavioural model of grants, starvation, writes and scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  localparam int LIM = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, reserve_valid = 1'b0;
  logic [4:0]  a_rd = '0, b_rd = '0, reserve_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, rs1_busy, rs2_busy, rf_we, reserve_conflict;
  logic [4:0]  rf_w;
  logic [31:0] rf_data;

  regfile_write_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .reserve_valid(reserve_valid), .reserve_rd(reserve_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_w(rf_w), .rf_data(rf_data),
    .reserve_conflict(reserve_conflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t wq[$];
  int  cq[$];

  // Behavioural model state
  bit mbusy [32];
  int losses   = 0;
  bit pend_we  = 0;
  int pend_rd  = 0;
  bit model_ok = 0;
  bit armed    = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus followed by model checks and model update.
  task automatic step(bit rn, bit av, logic [4:0] ar, logic [31:0] ad,
                      bit bv, logic [4:0] br, logic [31:0] bd,
                      bit rv, logic [4:0] rr, logic [4:0] s1, logic [4:0] s2);
    bit  starved, ea, eb, conf;
    wr_t e;
    @(posedge clk);
    #1;
    rst_n = rn; a_valid = av; a_rd = ar; a_data = ad;
    b_valid = bv; b_rd = br; b_data = bd;
    reserve_valid = rv; reserve_rd = rr; rs1 = s1; rs2 = s2;
    @(negedge clk);
    starved = (losses >= LIM);
    ea = !(bv && starved);
    eb = !av || starved;
    if (model_ok) begin
      check("a_ready", a_ready, ea);
      check("b_ready", b_ready, eb);
      check("rs1_busy", rs1_busy, (s1 != 0) && mbusy[s1]);
      check("rs2_busy", rs2_busy, (s2 != 0) && mbusy[s2]);
      check("one_handshake", (a_valid && a_ready) && (b_valid && b_ready), 0);
    end
    if (!rn) begin
      foreach (mbusy[i]) mbusy[i] = 0;
      losses   = 0;
      pend_we  = 0;
      model_ok = 1;
    end else if (model_ok) begin
      conf = rv && (rr != 0) && mbusy[rr] && !(pend_we && pend_rd == int'(rr));
      if (conf) cq.push_back(cyc + 1);
      if (pend_we) mbusy[pend_rd] = 0;
      if (rv && rr != 0) mbusy[rr] = 1;
      pend_we = 0;
      if (av && ea) begin
        if (ar != 0) begin
          e.cyc = cyc + 1; e.rd = ar; e.data = ad;
          wq.push_back(e);
          pend_we = 1; pend_rd = int'(ar);
        end
      end else if (bv && eb) begin
        if (br != 0) begin
          e.cyc = cyc + 1; e.rd = br; e.data = bd;
          wq.push_back(e);
          pend_we = 1; pend_rd = int'(br);
        end
      end
      if (bv && !eb) losses = (losses + 1 > LIM) ? LIM : losses + 1;
      else           losses = 0;
    end
  endtask

  // Monitor: pops expected writes and conflict pulses as the DUT shows them.
  always @(negedge clk) begin
    if (armed) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        n_vec++; n_fail++;
        $display("FAIL rf_we_missing: got rf_we=0 expected write rd=%0d at cycle %0d", wq[0].rd, wq[0].cyc);
        void'(wq.pop_front());
      end
      if (rf_we) begin
        if (wq.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL rf_we_unexpected: got rf_we=1 rd=%0d expected rf_we=0 (cycle %0d)", rf_w, cyc);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("rf_we_cycle", cyc, e.cyc);
          check("rf_w", rf_w, e.rd);
          check("rf_data", rf_data, e.data);
        end
      end
      while (cq.size() > 0 && cq[0] < cyc) begin
        n_vec++; n_fail++;
        $display("FAIL conflict_missing: got 0 expected pulse at cycle %0d", cq[0]);
        void'(cq.pop_front());
      end
      if (reserve_conflict) begin
        if (cq.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL conflict_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          check("conflict_cycle", cyc, cq.pop_front());
        end
      end
    end
  end

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 5))
      0: return 5'd0;
      1: return 5'd7;
      2: return 5'd9;
      3: return 5'd3;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    // Reset with A requesting: nothing must come out of it.
    step(0, 1, 5'd5, 32'h1111, 0, 0, 0, 1, 5'd4, 0, 0);
    armed = 1;
    step(0, 1, 5'd5, 32'h2222, 0, 0, 0, 1, 5'd4, 5'd4, 5'd5);
    step(1, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 5'd4, 5'd5);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_reset_rf_w", rf_w, 5'd5);
    check("post_reset_rf_data", rf_data, 32'h1234);

    // Continuous contention: A wins three, B wins the fourth, repeating.
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 5'(10 + (i % 4)), 32'hA000 + i, 1, 5'd20, 32'hB000 + i, 0, 0, 0, 0);
      check("b_win_pattern", b_ready, (i % 4) == 3);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Scoreboard lifecycle on r7 and set/clear collision on r9.
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    step(1, 0, 0, 0, 1, 5'd7, 32'hDEADBEEF, 1, 5'd9, 5'd7, 5'd9);
    step(1, 0, 0, 0, 1, 5'd9, 32'h9999, 0, 0, 5'd7, 5'd9);
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd7, 5'd9);
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd7, 5'd9);
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd9, 5'd0);
    step(1, 1, 5'd0, 32'h5, 0, 0, 0, 0, 0, 5'd0, 5'd9);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd9);

    // Handshake immediately followed by a reset edge.
    step(1, 1, 5'd12, 32'h77, 0, 0, 0, 1, 5'd12, 0, 0);
    step(0, 1, 5'd13, 32'h88, 1, 5'd14, 32'h99, 1, 5'd15, 5'd12, 5'd15);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd12, 5'd15);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 9) < 6), pick_reg(), $urandom(),
           ($urandom_range(0, 9) < 6), pick_reg(), $urandom(),
           ($urandom_range(0, 1) == 1), pick_reg(), pick_reg(), pick_reg());
    end

    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("writes_drained", wq.size(), 0);
    check("conflicts_drained", cq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
